// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one alu_core between NUM_REQ requesters.
// Operands are latched at accept, executed for one cycle, and the result is held on a valid/ready channel.
`define SUBMODULE_DISABLE_WAVES_ALU_CORE

// Combinational 32-bit ALU; op codes are opaque to the arbiter above it.
module alu_core (
  input  logic [4:0]  alu_control,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic [31:0] rd_write_val
);
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;

  always_comb begin
    rd_write_val = 32'd0;
    case (alu_control)
      ALU_ADD:  rd_write_val = rs1_val + rs2_val;
      ALU_SUB:  rd_write_val = rs1_val - rs2_val;
      ALU_AND:  rd_write_val = rs1_val & rs2_val;
      ALU_OR:   rd_write_val = rs1_val | rs2_val;
      ALU_XOR:  rd_write_val = rs1_val ^ rs2_val;
      ALU_SLL:  rd_write_val = rs1_val << rs2_val[4:0];
      ALU_SRL:  rd_write_val = rs1_val >> rs2_val[4:0];
      ALU_SRA:  rd_write_val = $unsigned($signed(rs1_val) >>> rs2_val[4:0]);
      ALU_SLT:  rd_write_val = {31'd0, $signed(rs1_val) < $signed(rs2_val)};
      ALU_SLTU: rd_write_val = {31'd0, rs1_val < rs2_val};
      default:  rd_write_val = 32'd0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_rs1_val,
  input  logic [NUM_REQ*32-1:0] req_rs2_val,
  input  logic [NUM_REQ*5-1:0] req_alu_control,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 busy
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // req_ready never depends on itself; rsp_valid stays high with stable data until rsp_ready.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [ID_W:0] NREQ = NUM_REQ[ID_W:0];

  logic [1:0]         r_state;
  logic [ID_W-1:0]    r_prio;
  logic [ID_W-1:0]    r_owner;
  logic [31:0]        r_op1;
  logic [31:0]        r_op2;
  logic [4:0]         r_ctl;
  logic [ID_W-1:0]    r_rsp_id;
  logic [31:0]        r_rsp_data;

  logic               w_found;
  logic [ID_W-1:0]    w_win;
  logic [NUM_REQ-1:0] w_grant;
  logic [31:0]        w_sel_rs1;
  logic [31:0]        w_sel_rs2;
  logic [4:0]         w_sel_ctl;
  logic [31:0]        w_alu_result;
  logic               w_accept;

  // (base + off) mod NUM_REQ, with base < NUM_REQ and off <= NUM_REQ.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base,
                                             input logic [ID_W:0]   off);
    logic [ID_W:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return sum[ID_W-1:0];
  endfunction

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[rr_idx(r_prio, i[ID_W:0])]) begin
        w_found = 1'b1;
        w_win   = rr_idx(r_prio, i[ID_W:0]);
      end
    end
  end

  always_comb begin
    w_grant   = '0;
    w_sel_rs1 = 32'd0;
    w_sel_rs2 = 32'd0;
    w_sel_ctl = 5'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == i[ID_W-1:0]) begin
        w_grant[i] = w_found;
        w_sel_rs1  = req_rs1_val[i*32 +: 32];
        w_sel_rs2  = req_rs2_val[i*32 +: 32];
        w_sel_ctl  = req_alu_control[i*5 +: 5];
      end
    end
  end

  assign req_ready = (r_state == S_IDLE && !rst) ? w_grant : '0;
  assign w_accept  = |(req_valid & req_ready);

  // The core only ever sees latched operands, so live request changes cannot leak in.
  alu_core u_alu_core (
    .alu_control  (r_ctl),
    .rs1_val      (r_op1),
    .rs2_val      (r_op2),
    .rd_write_val (w_alu_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_prio     <= '0;
      r_owner    <= '0;
      r_op1      <= 32'd0;
      r_op2      <= 32'd0;
      r_ctl      <= 5'd0;
      r_rsp_id   <= '0;
      r_rsp_data <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op1   <= w_sel_rs1;
            r_op2   <= w_sel_rs2;
            r_ctl   <= w_sel_ctl;
            r_owner <= w_win;
            r_prio  <= rr_idx(w_win, {{ID_W{1'b0}}, 1'b1});
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_data <= w_alu_result;
          r_rsp_id   <= r_owner;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state == S_EXEC) || (r_state == S_RESP);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a 2-port instance for most scenarios and a 3-port one for rotation.
module tb_alu_arbiter;
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_XOR = 5'd4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 2-requester instance
  logic [1:0]  req_valid, req_ready;
  logic [63:0] rs1, rs2;
  logic [9:0]  ctl;
  logic        rsp_valid, rsp_ready, busy;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_data;

  // 3-requester instance
  logic [2:0]  v3, rdy3;
  logic [95:0] a3, b3;
  logic [14:0] c3;
  logic        rv3, rr3, busy3;
  logic [1:0]  id3;
  logic [31:0] d3;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];

  alu_arbiter #(.NUM_REQ(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1_val(rs1), .req_rs2_val(rs2), .req_alu_control(ctl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  alu_arbiter #(.NUM_REQ(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3),
    .req_rs1_val(a3), .req_rs2_val(b3), .req_alu_control(c3),
    .rsp_valid(rv3), .rsp_ready(rr3), .rsp_id(id3),
    .rsp_data(d3), .busy(busy3)
  );

  // driver tasks: inputs change 1 time unit after the rising edge, outputs are read on the falling edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; v3 = 3'b111; rsp_ready = 1'b0; rr3 = 1'b0;
    rs1 = '0; rs2 = '0; ctl = '0; a3 = '0; b3 = '0; c3 = '0;
    tick(); settle();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready2: got %b want 00", req_ready); end
    checks++; if (rdy3 !== 3'b000) begin errors++; $display("FAIL reset_ready3: got %b want 000", rdy3); end
    tick();
    rst = 1'b0; req_valid = 2'b00; v3 = 3'b000;
    settle();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %h want 0", rsp_id); end
    checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_idle_ready: got %b want 00", req_ready); end
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready = 1'b1; rs1[31:0] = 32'd5; rs2[31:0] = 32'd7; ctl[4:0] = OP_ADD; req_valid = 2'b01;
    settle();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
    tick(); req_valid = 2'b00; settle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_exec: got %b want 1", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_exec: got %b want 0", rsp_valid); end
    tick(); settle();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_rsp_id: got %h want 0", rsp_id); end
    checks++; if (rsp_data !== 32'd12) begin errors++; $display("FAIL single_rsp_data: got %h want 0000000c", rsp_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_resp: got %b want 1", busy); end
    tick(); settle();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done: got valid=%b busy=%b want 0 0", rsp_valid, busy); end
    checks++; if (rsp_data !== 32'd12) begin errors++; $display("FAIL single_data_kept: got %h want 0000000c", rsp_data); end
  endtask

  task automatic test_fairness2();
    int last_k, ngr, nrsp;
    logic [1:0] exp_id;
    logic exp_g;
    do_reset();
    rs1 = {32'd10, 32'd1}; rs2 = {32'd20, 32'd1}; ctl = {OP_ADD, OP_ADD};
    rsp_ready = 1'b1; req_valid = 2'b11;
    exp_q = {2'd0, 2'd1, 2'd0, 2'd1};
    last_k = 0; ngr = 0; nrsp = 0;
    for (int k = 0; k < 12; k++) begin
      settle();
      if (req_ready !== 2'b00) begin
        exp_g = (ngr % 2 == 1);
        checks++; if (req_ready !== (exp_g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL fair2_grant#%0d: got %b want port %0d", ngr, req_ready, exp_g); end
        checks++; if (k - last_k !== (ngr == 0 ? 0 : 3)) begin errors++; $display("FAIL fair2_spacing#%0d: got %0d cycles want 3", ngr, k - last_k); end
        last_k = k; ngr++;
      end
      if (rsp_valid === 1'b1 && exp_q.size() > 0) begin
        exp_id = exp_q.pop_front();
        checks++; if (rsp_id !== exp_id[0]) begin errors++; $display("FAIL fair2_rsp_id#%0d: got %h want %h", nrsp, rsp_id, exp_id); end
        checks++; if (rsp_data !== (exp_id[0] ? 32'd30 : 32'd2)) begin errors++; $display("FAIL fair2_rsp_data#%0d: got %h", nrsp, rsp_data); end
        nrsp++;
      end
      tick();
    end
    req_valid = 2'b00;
    checks++; if (ngr !== 4 || nrsp !== 4) begin errors++; $display("FAIL fair2_count: got grants=%0d rsps=%0d want 4 4", ngr, nrsp); end
  endtask

  task automatic test_fairness3();
    int ngr;
    logic [1:0] gi, exp_g;
    do_reset();
    rr3 = 1'b1; a3 = {32'd3, 32'd2, 32'd1}; b3 = '0; c3 = {OP_ADD, OP_ADD, OP_ADD};
    v3 = 3'b110;
    exp_q = {2'd1, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1};
    ngr = 0;
    for (int k = 0; k < 18; k++) begin
      settle();
      if (rdy3 !== 3'b000) begin
        gi = rdy3[2] ? 2'd2 : (rdy3[1] ? 2'd1 : 2'd0);
        exp_g = (exp_q.size() > 0) ? exp_q.pop_front() : 2'd3;
        checks++; if (!$onehot(rdy3) || gi !== exp_g) begin errors++; $display("FAIL fair3_grant#%0d: got %b want port %0d", ngr, rdy3, exp_g); end
        ngr++;
      end
      if (rv3 === 1'b1) begin
        checks++; if (d3 !== {30'd0, id3} + 32'd1) begin errors++; $display("FAIL fair3_data: got %h for id %0d", d3, id3); end
      end
      tick();
      if (ngr == 3 && v3 == 3'b110) v3 = 3'b111;
    end
    v3 = 3'b000;
    checks++; if (ngr !== 6) begin errors++; $display("FAIL fair3_count: got %0d want 6", ngr); end
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b0; rs1[31:0] = 32'd0; rs2[31:0] = 32'd1; ctl[4:0] = OP_SUB; req_valid = 2'b01;
    settle();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_first_ready: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b10; rs1[63:32] = 32'd1; rs2[63:32] = 32'd1; ctl[9:5] = OP_ADD;
    settle();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_exec_ready: got %b want 00", req_ready); end
    tick();
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFF || rsp_id !== 1'b0) begin errors++; $display("FAIL bp_hold#%0d: got valid=%b data=%h id=%h want 1 ffffffff 0", i, rsp_valid, rsp_data, rsp_id); end
      checks++; if (busy !== 1'b1 || req_ready !== 2'b00) begin errors++; $display("FAIL bp_stall#%0d: got busy=%b ready=%b want 1 00", i, busy, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    settle();
    checks++; if (rsp_valid !== 1'b1 || req_ready !== 2'b00) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b want 1 00", rsp_valid, req_ready); end
    tick(); settle();
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_next_grant: got %b want 10", req_ready); end
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bp_after: got valid=%b data=%h want 0 ffffffff", rsp_valid, rsp_data); end
    tick(); req_valid = 2'b00;
    tick(); settle();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'd2) begin errors++; $display("FAIL bp_port1_rsp: got valid=%b id=%h data=%h want 1 1 2", rsp_valid, rsp_id, rsp_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    rsp_ready = 1'b1; rs1[31:0] = 32'd9; rs2[31:0] = 32'd9; ctl[4:0] = OP_ADD;
    rs1[63:32] = 32'd4; rs2[63:32] = 32'd4; ctl[9:5] = OP_ADD; req_valid = 2'b01;
    settle();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmid_grant: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00; rst = 1'b1;
    settle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_exec_busy: got %b want 1", busy); end
    tick(); rst = 1'b0; settle();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 32'd0) begin errors++; $display("FAIL rmid_cleared: got valid=%b busy=%b data=%h want 0 0 0", rsp_valid, busy, rsp_data); end
    tick(); req_valid = 2'b11; settle();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmid_prio0: got %b want 01", req_ready); end
    tick(); req_valid = 2'b00;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      settle();
      if (rsp_valid === 1'b1) seen = 1'b1;
      else tick();
    end
    checks++; if (!seen || rsp_id !== 1'b0 || rsp_data !== 32'd18) begin errors++; $display("FAIL rmid_rsp: got seen=%b id=%h data=%h want 1 0 12", seen, rsp_id, rsp_data); end
    tick();
  endtask

  task automatic test_operand_isolation();
    rsp_ready = 1'b1; rs1[31:0] = 32'd3; rs2[31:0] = 32'd5; ctl[4:0] = OP_XOR; req_valid = 2'b01;
    settle();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL iso_grant: got %b want 01", req_ready); end
    tick();
    rs1[31:0] = 32'd100; req_valid = 2'b00;
    tick(); settle();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd6) begin errors++; $display("FAIL iso_data: got valid=%b data=%h want 1 00000006", rsp_valid, rsp_data); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_fairness2();
    test_fairness3();
    test_backpressure();
    test_reset_mid();
    test_operand_isolation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
